// File: rtl/branch_resolver_pipe.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver_pipe
// Purpose  : Branch/shift/compare unit. It resolves jumps and detects
//            mispredictions. Predictor updates are queued in a FIFO.
// Options  : BR_COMPRESSED_EN enables the compressed uops 18-21.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolver_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int UPD_DEPTH  = 4,
    parameter int TICKET_W   = 3,
    parameter int RAT_W      = 2,
    parameter int DEST_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_uop,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  in_pred_taken,
    input  logic [DATA_WIDTH-1:0] in_pred_target,
    input  logic [TICKET_W-1:0]   in_ticket,
    input  logic [RAT_W-1:0]      in_rat_id,
    input  logic [DEST_W-1:0]     in_dest,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_data,
    output logic [TICKET_W-1:0]   ex_ticket,
    output logic [DEST_W-1:0]     ex_dest,
    output logic                  ex_exc_valid,
    output logic [4:0]            ex_exc_cause,
    output logic                  redir_valid,
    output logic [DATA_WIDTH-1:0] redir_pc,
    output logic [TICKET_W-1:0]   redir_ticket,
    output logic [RAT_W-1:0]      redir_rat_id,
    output logic                  pr_valid,
    input  logic                  pr_ready,
    output logic                  pr_taken,
    output logic                  pr_is_comp,
    output logic [DATA_WIDTH-1:0] pr_orig_pc,
    output logic [DATA_WIDTH-1:0] pr_target,
    output logic [TICKET_W-1:0]   pr_ticket,
    output logic [RAT_W-1:0]      pr_rat_id
);

    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int PTRW = $clog2(UPD_DEPTH);
    localparam int CNTW = PTRW + 1;

    localparam logic [4:0] UOP_SLT   = 5'd0;
    localparam logic [4:0] UOP_SLTU  = 5'd1;
    localparam logic [4:0] UOP_SLTI  = 5'd2;
    localparam logic [4:0] UOP_SLTIU = 5'd3;
    localparam logic [4:0] UOP_SLL   = 5'd4;
    localparam logic [4:0] UOP_SRL   = 5'd5;
    localparam logic [4:0] UOP_SRA   = 5'd6;
    localparam logic [4:0] UOP_SLLI  = 5'd7;
    localparam logic [4:0] UOP_SRLI  = 5'd8;
    localparam logic [4:0] UOP_SRAI  = 5'd9;
    localparam logic [4:0] UOP_JAL   = 5'd10;
    localparam logic [4:0] UOP_JALR  = 5'd11;
    localparam logic [4:0] UOP_BEQ   = 5'd12;
    localparam logic [4:0] UOP_BNE   = 5'd13;
    localparam logic [4:0] UOP_BLT   = 5'd14;
    localparam logic [4:0] UOP_BLTU  = 5'd15;
    localparam logic [4:0] UOP_BGE   = 5'd16;
    localparam logic [4:0] UOP_BGEU  = 5'd17;
`ifdef BR_COMPRESSED_EN
    localparam logic [4:0] UOP_CJR   = 5'd18;
    localparam logic [4:0] UOP_CJ    = 5'd19;
    localparam logic [4:0] UOP_CBEQZ = 5'd20;
    localparam logic [4:0] UOP_CBNEZ = 5'd21;
`endif

    typedef struct packed {
        logic                  taken;
        logic                  is_comp;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
        logic [TICKET_W-1:0]   ticket;
        logic [RAT_W-1:0]      rat_id;
    } upd_entry_t;

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    logic                  imm_cmp;
    logic                  imm_shift;
    logic [DATA_WIDTH-1:0] cmp_b;
    logic [SHW-1:0]        shamt;
    logic                  lt_s;
    logic                  lt_u;
    logic                  eq;
    logic                  data1_zero;
    logic [DATA_WIDTH-1:0] br_target;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] link4;
    logic [DATA_WIDTH-1:0] link2;
    logic                  misaligned;

    assign imm_cmp    = (in_uop == UOP_SLTI) || (in_uop == UOP_SLTIU);
    assign imm_shift  = (in_uop == UOP_SLLI) || (in_uop == UOP_SRLI) || (in_uop == UOP_SRAI);
    assign cmp_b      = imm_cmp ? in_imm : in_data2;
    assign shamt      = imm_shift ? in_imm[SHW-1:0] : in_data2[SHW-1:0];
    assign lt_s       = $signed(in_data1) < $signed(cmp_b);
    assign lt_u       = in_data1 < cmp_b;
    assign eq         = in_data1 == in_data2;
    assign data1_zero = in_data1 == '0;
    assign br_target  = in_pc + in_imm;
    assign jalr_sum   = in_data1 + in_imm;
    assign link4      = in_pc + DATA_WIDTH'(4);
    assign link2      = in_pc + DATA_WIDTH'(2);

`ifdef BR_COMPRESSED_EN
    assign misaligned = br_target[0];
`else
    assign misaligned = |br_target[1:0];
`endif

    // ------------------------------------------------------------------
    // Decode / resolve
    // ------------------------------------------------------------------
    logic                  is_jump;
    logic                  is_comp;
    logic                  taken;
    logic                  exc;
    logic [4:0]            cause;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] target;

    always_comb begin
        result  = '0;
        target  = br_target;
        taken   = 1'b0;
        is_jump = 1'b0;
        is_comp = 1'b0;
        exc     = 1'b0;
        cause   = 5'd0;
        case (in_uop)
            UOP_SLT, UOP_SLTI:   result = DATA_WIDTH'(lt_s);
            UOP_SLTU, UOP_SLTIU: result = DATA_WIDTH'(lt_u);
            UOP_SLL, UOP_SLLI:   result = in_data1 << shamt;
            UOP_SRL, UOP_SRLI:   result = in_data1 >> shamt;
            UOP_SRA, UOP_SRAI:   result = $unsigned($signed(in_data1) >>> shamt);
            UOP_JAL: begin
                is_jump = 1'b1;
                taken   = 1'b1;
                result  = link4;
                exc     = misaligned;
                cause   = misaligned ? 5'd1 : 5'd0;
            end
            UOP_JALR: begin
                is_jump = 1'b1;
                taken   = 1'b1;
                target  = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
                result  = link4;
            end
            UOP_BEQ:  begin is_jump = 1'b1; taken = eq;    end
            UOP_BNE:  begin is_jump = 1'b1; taken = !eq;   end
            UOP_BLT:  begin is_jump = 1'b1; taken = lt_s;  end
            UOP_BLTU: begin is_jump = 1'b1; taken = lt_u;  end
            UOP_BGE:  begin is_jump = 1'b1; taken = !lt_s; end
            UOP_BGEU: begin is_jump = 1'b1; taken = !lt_u; end
`ifdef BR_COMPRESSED_EN
            UOP_CJR: begin
                is_jump = 1'b1;
                is_comp = 1'b1;
                taken   = 1'b1;
                target  = in_data1;
                result  = link2;
            end
            UOP_CJ: begin
                is_jump = 1'b1;
                is_comp = 1'b1;
                taken   = 1'b1;
                result  = link2;
            end
            UOP_CBEQZ: begin is_jump = 1'b1; is_comp = 1'b1; taken = data1_zero;  end
            UOP_CBNEZ: begin is_jump = 1'b1; is_comp = 1'b1; taken = !data1_zero; end
`endif
            default: begin
                exc   = 1'b1;
                cause = 5'd2;
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] fallthrough;
    logic [DATA_WIDTH-1:0] resolved_pc;
    logic                  mispredict;

    assign fallthrough = is_comp ? link2 : link4;
    assign resolved_pc = taken ? target : fallthrough;
    assign mispredict  = is_jump &&
                         ((taken != in_pred_taken) || (taken && (target != in_pred_target)));

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic [CNTW-1:0] count_q, count_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic            accept;
    logic            push;
    logic            pop;

    assign in_ready = count_q != CNTW'(UPD_DEPTH);
    assign pr_valid = count_q != '0;
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && is_jump;
    assign pop      = pr_valid && pr_ready;
    assign wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    assign count_d  = count_q + CNTW'(push) - CNTW'(pop);

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------
    upd_entry_t mem_q [UPD_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{taken:   taken,
                                     is_comp: is_comp,
                                     pc:      in_pc,
                                     target:  resolved_pc,
                                     ticket:  in_ticket,
                                     rat_id:  in_rat_id};
            end
        end
    end

    assign pr_taken   = mem_q[rd_ptr_q].taken;
    assign pr_is_comp = mem_q[rd_ptr_q].is_comp;
    assign pr_orig_pc = mem_q[rd_ptr_q].pc;
    assign pr_target  = mem_q[rd_ptr_q].target;
    assign pr_ticket  = mem_q[rd_ptr_q].ticket;
    assign pr_rat_id  = mem_q[rd_ptr_q].rat_id;

    // ------------------------------------------------------------------
    // Writeback / redirect register; valids last exactly one cycle
    // ------------------------------------------------------------------
    logic                  ex_valid_q, ex_exc_valid_q, redir_valid_q;
    logic [DATA_WIDTH-1:0] ex_data_q, redir_pc_q;
    logic [TICKET_W-1:0]   ex_ticket_q, redir_ticket_q;
    logic [DEST_W-1:0]     ex_dest_q;
    logic [4:0]            ex_exc_cause_q;
    logic [RAT_W-1:0]      redir_rat_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_exc_valid_q <= 1'b0;
            redir_valid_q  <= 1'b0;
            ex_data_q      <= '0;
            ex_ticket_q    <= '0;
            ex_dest_q      <= '0;
            ex_exc_cause_q <= '0;
            redir_pc_q     <= '0;
            redir_ticket_q <= '0;
            redir_rat_id_q <= '0;
        end else begin
            ex_valid_q     <= accept;
            ex_exc_valid_q <= accept && exc;
            redir_valid_q  <= accept && mispredict;
            if (accept) begin
                ex_data_q      <= result;
                ex_ticket_q    <= in_ticket;
                ex_dest_q      <= in_dest;
                ex_exc_cause_q <= cause;
                redir_pc_q     <= resolved_pc;
                redir_ticket_q <= in_ticket;
                redir_rat_id_q <= in_rat_id;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_data      = ex_data_q;
    assign ex_ticket    = ex_ticket_q;
    assign ex_dest      = ex_dest_q;
    assign ex_exc_valid = ex_exc_valid_q;
    assign ex_exc_cause = ex_exc_cause_q;
    assign redir_valid  = redir_valid_q;
    assign redir_pc     = redir_pc_q;
    assign redir_ticket = redir_ticket_q;
    assign redir_rat_id = redir_rat_id_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver_pipe
// Purpose  : Self-checking bench for branch_resolver_pipe (vectors + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver_pipe;

    localparam int DEPTH = 4;
`ifdef BR_COMPRESSED_EN
    localparam bit COMP_EN = 1'b1;
`else
    localparam bit COMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_pred_taken;
    logic [4:0]  in_uop;
    logic [31:0] in_data1, in_data2, in_imm, in_pc, in_pred_target;
    logic [2:0]  in_ticket;
    logic [1:0]  in_rat_id;
    logic [5:0]  in_dest;
    logic        ex_valid, ex_exc_valid, redir_valid;
    logic [31:0] ex_data, redir_pc;
    logic [2:0]  ex_ticket, redir_ticket;
    logic [5:0]  ex_dest;
    logic [4:0]  ex_exc_cause;
    logic [1:0]  redir_rat_id;
    logic        pr_valid, pr_ready, pr_taken, pr_is_comp;
    logic [31:0] pr_orig_pc, pr_target;
    logic [2:0]  pr_ticket;
    logic [1:0]  pr_rat_id;

    branch_resolver_pipe #(.DATA_WIDTH(32), .UPD_DEPTH(DEPTH), .TICKET_W(3), .RAT_W(2), .DEST_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm), .in_pc(in_pc),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_ticket(in_ticket), .in_rat_id(in_rat_id), .in_dest(in_dest),
        .ex_valid(ex_valid), .ex_data(ex_data), .ex_ticket(ex_ticket), .ex_dest(ex_dest),
        .ex_exc_valid(ex_exc_valid), .ex_exc_cause(ex_exc_cause),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ticket(redir_ticket), .redir_rat_id(redir_rat_id),
        .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_taken(pr_taken), .pr_is_comp(pr_is_comp),
        .pr_orig_pc(pr_orig_pc), .pr_target(pr_target), .pr_ticket(pr_ticket), .pr_rat_id(pr_rat_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  uop;
        logic [31:0] a, b, imm, pc, ptgt;
        bit          pt;
        logic [2:0]  ticket;
        logic [1:0]  rat;
        logic [5:0]  dest;
        bit          fl;
        bit          prr;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        bit          exc;
        logic [4:0]  cause;
        bit          jump, taken, comp, mis;
        logic [31:0] rpc;
    } res_t;

    typedef struct {
        bit          taken, comp;
        logic [31:0] pc, tgt;
        logic [2:0]  ticket;
        logic [1:0]  rat;
    } pr_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [31:0] e_data;
        bit          e_exc;
        logic [4:0]  e_cause;
        bit          e_redir;
        logic [31:0] e_rpc;
        bit          e_push;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    pr_t        mq[$];
    logic [2:0] popped[$];
    vec_t       vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural meaning of each uop, written from the ISA rules.
    function automatic res_t model(input stim_t s);
        res_t   r;
        longint sa, sb, si;
        int     sh, shi;
        logic [31:0] tgt;
        r  = '{default: 0};
        sa = $signed(s.a);
        sb = $signed(s.b);
        si = $signed(s.imm);
        sh  = int'(s.b % 32);
        shi = int'(s.imm % 32);
        tgt = s.pc + s.imm;
        case (int'(s.uop))
            0:  r.data = 32'(sa < sb);
            1:  r.data = 32'(s.a < s.b);
            2:  r.data = 32'(sa < si);
            3:  r.data = 32'(s.a < s.imm);
            4:  r.data = s.a << sh;
            5:  r.data = s.a >> sh;
            6:  r.data = 32'(sa >>> sh);
            7:  r.data = s.a << shi;
            8:  r.data = s.a >> shi;
            9:  r.data = 32'(sa >>> shi);
            10: begin
                r.jump = 1; r.taken = 1; r.data = s.pc + 4;
                r.exc  = COMP_EN ? (tgt % 2 != 0) : (tgt % 4 != 0);
                r.cause = r.exc ? 5'd1 : 5'd0;
            end
            11: begin r.jump = 1; r.taken = 1; r.data = s.pc + 4; tgt = ((s.a + s.imm) >> 1) << 1; end
            12: begin r.jump = 1; r.taken = (s.a == s.b); end
            13: begin r.jump = 1; r.taken = (s.a != s.b); end
            14: begin r.jump = 1; r.taken = (sa < sb);   end
            15: begin r.jump = 1; r.taken = (s.a < s.b); end
            16: begin r.jump = 1; r.taken = (sa >= sb);  end
            17: begin r.jump = 1; r.taken = (s.a >= s.b); end
            18, 19, 20, 21: begin
                if (!COMP_EN) begin
                    r.exc = 1; r.cause = 5'd2;
                end else begin
                    r.jump = 1; r.comp = 1;
                    if (s.uop == 18) begin r.taken = 1; tgt = s.a; r.data = s.pc + 2; end
                    else if (s.uop == 19) begin r.taken = 1; r.data = s.pc + 2; end
                    else if (s.uop == 20) r.taken = (s.a == 0);
                    else r.taken = (s.a != 0);
                end
            end
            default: begin r.exc = 1; r.cause = 5'd2; end
        endcase
        if (r.jump) begin
            r.rpc = r.taken ? tgt : s.pc + (r.comp ? 2 : 4);
            r.mis = (r.taken != s.pt) || (r.taken && tgt != s.ptgt);
        end
        return r;
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input stim_t s);
        res_t r;
        bit   acc, pop;
        in_valid = s.v; in_uop = s.uop; in_data1 = s.a; in_data2 = s.b; in_imm = s.imm;
        in_pc = s.pc; in_pred_taken = s.pt; in_pred_target = s.ptgt;
        in_ticket = s.ticket; in_rat_id = s.rat; in_dest = s.dest;
        flush = s.fl; pr_ready = s.prr;
        #1;
        check("in_ready", in_ready, mq.size() < DEPTH);
        check("pr_valid", pr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("pr_taken", pr_taken, mq[0].taken);
            check("pr_is_comp", pr_is_comp, mq[0].comp);
            check("pr_orig_pc", pr_orig_pc, mq[0].pc);
            check("pr_target", pr_target, mq[0].tgt);
            check("pr_ticket", pr_ticket, mq[0].ticket);
            check("pr_rat_id", pr_rat_id, mq[0].rat);
        end
        r   = model(s);
        acc = s.v && (mq.size() < DEPTH) && !s.fl;
        pop = s.prr && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            popped.push_back(mq[0].ticket);
            mq.delete(0);
        end
        if (acc && r.jump)
            mq.push_back('{taken: r.taken, comp: r.comp, pc: s.pc, tgt: r.rpc, ticket: s.ticket, rat: s.rat});
        check("ex_valid", ex_valid, acc);
        check("redir_valid", redir_valid, acc && r.jump && r.mis);
        if (acc) begin
            check("ex_data", ex_data, r.data);
            check("ex_exc_valid", ex_exc_valid, r.exc);
            if (r.exc) check("ex_exc_cause", ex_exc_cause, r.cause);
            check("ex_ticket", ex_ticket, s.ticket);
            check("ex_dest", ex_dest, s.dest);
            if (r.jump && r.mis) begin
                check("redir_pc", redir_pc, r.rpc);
                check("redir_ticket", redir_ticket, s.ticket);
                check("redir_rat_id", redir_rat_id, s.rat);
            end
        end else begin
            check("ex_exc_valid_idle", ex_exc_valid, 1'b0);
        end
    endtask

    function automatic stim_t mk(input bit v, input int uop, input logic [31:0] a, b, imm, pc,
                                 input bit pt, input logic [31:0] ptgt, input int tk, input bit prr);
        stim_t s;
        s = '{v: v, uop: 5'(uop), a: a, b: b, imm: imm, pc: pc, ptgt: ptgt, pt: pt,
              ticket: 3'(tk), rat: 2'(tk + 1), dest: 6'(tk + 9), fl: 1'b0, prr: prr};
        return s;
    endfunction

    task automatic idle(input bit prr);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, prr));
    endtask

    task automatic add(input string n, input stim_t s, input logic [31:0] ed, input bit ee,
                       input logic [4:0] ec, input bit er, input logic [31:0] erpc, input bit ep);
        vec_t v;
        v = '{name: n, s: s, e_data: ed, e_exc: ee, e_cause: ec, e_redir: er, e_rpc: erpc, e_push: ep};
        vecs.push_back(v);
    endtask

    initial begin
        stim_t s;
        rst = 1; flush = 0; in_valid = 0; in_uop = 0; in_data1 = 0; in_data2 = 0; in_imm = 0;
        in_pc = 0; in_pred_taken = 0; in_pred_target = 0; in_ticket = 0; in_rat_id = 0;
        in_dest = 0; pr_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset ex_valid", ex_valid, 0);
        check("reset redir_valid", redir_valid, 0);
        check("reset pr_valid", pr_valid, 0);
        check("reset ex_exc_valid", ex_exc_valid, 0);
        check("reset ex_data", ex_data, 0);
        check("reset redir_pc", redir_pc, 0);
        check("reset pr_target", pr_target, 0);
        check("reset in_ready", in_ready, 1);

        // ---------------- directed vectors ----------------
        add("BLT",   mk(1, 14, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0, 1, 1), 0, 0, 0, 1, 32'h120, 1);
        add("JALR",  mk(1, 11, 32'h203, 0, 0, 32'h300, 1, 32'h202, 2, 1), 32'h304, 0, 0, 0, 0, 1);
        add("SRA",   mk(1, 6, 32'h8000_0000, 4, 0, 32'h10, 0, 0, 3, 1), 32'hF800_0000, 0, 0, 0, 0, 0);
        add("SLT",   mk(1, 0, 32'hFFFF_FFFB, 3, 0, 0, 0, 0, 4, 1), 1, 0, 0, 0, 0, 0);
        add("SLTU",  mk(1, 1, 32'hFFFF_FFFB, 3, 0, 0, 0, 0, 5, 1), 0, 0, 0, 0, 0, 0);
        add("SLTI",  mk(1, 2, 2, 0, 32'hFFFF_FFFF, 0, 0, 0, 6, 1), 0, 0, 0, 0, 0, 0);
        add("SRLI",  mk(1, 8, 32'h8000_0000, 0, 32'h24, 0, 0, 0, 7, 1), 32'h0800_0000, 0, 0, 0, 0, 0);
        add("SLL",   mk(1, 4, 1, 32'h21, 0, 0, 0, 0, 0, 1), 2, 0, 0, 0, 0, 0);
        add("JAL",   mk(1, 10, 0, 0, 32'h10, 32'h1000, 1, 32'h1010, 1, 1), 32'h1004, 0, 0, 0, 0, 1);
        add("JALmis", mk(1, 10, 0, 0, 32'h5, 32'h1000, 1, 32'h1005, 2, 1), 32'h1004, 1, 1, 0, 0, 1);
        add("BGEU",  mk(1, 17, 5, 5, 32'hFFFF_FFF0, 32'h40, 1, 32'h30, 3, 1), 0, 0, 0, 0, 0, 1);
        add("BNEnt", mk(1, 13, 7, 7, 32'h10, 32'h80, 1, 32'h90, 4, 1), 0, 0, 0, 1, 32'h84, 1);
        add("BEQtg", mk(1, 12, 9, 9, 32'h10, 32'h10, 1, 32'h24, 5, 1), 0, 0, 0, 1, 32'h20, 1);
        add("ILL",   mk(1, 25, 1, 2, 3, 32'h50, 0, 0, 6, 1), 0, 1, 2, 0, 0, 0);
`ifdef BR_COMPRESSED_EN
        add("CBEQZ", mk(1, 20, 0, 0, 8, 32'h200, 0, 0, 7, 1), 0, 0, 0, 1, 32'h208, 1);
`else
        add("CBEQZ", mk(1, 20, 0, 0, 8, 32'h200, 0, 0, 7, 1), 0, 1, 2, 0, 0, 0);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s);
            check({vecs[i].name, " data"}, ex_data, vecs[i].e_data);
            check({vecs[i].name, " exc"}, ex_exc_valid, vecs[i].e_exc);
            if (vecs[i].e_exc) check({vecs[i].name, " cause"}, ex_exc_cause, vecs[i].e_cause);
            check({vecs[i].name, " redir"}, redir_valid, vecs[i].e_redir);
            if (vecs[i].e_redir) check({vecs[i].name, " redir_pc"}, redir_pc, vecs[i].e_rpc);
            check({vecs[i].name, " push"}, pr_valid, vecs[i].e_push);
        end
        idle(1); idle(1);

        // ---------------- FIFO full / ordering ----------------
        popped.delete();
        for (int i = 0; i <= DEPTH; i++)
            step(mk(1, 12, 3, 3, 32'h8, 32'h400 + 32'(i * 4), 1, 32'h408 + 32'(i * 4), i, 0));
        check("full in_ready", in_ready, 0);
        check("full ex_valid", ex_valid, 0);
        step(mk(1, 12, 3, 3, 32'h8, 32'h500, 1, 32'h508, 7, 1)); // pop while full: not accepted
        check("pop-while-full ex_valid", ex_valid, 0);
        check("slot freed in_ready", in_ready, 1);
        repeat (DEPTH + 1) idle(1);
        check("drain count", popped.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("drain order", popped[i], 3'(i));

        // ---------------- flush ----------------
        step(mk(1, 12, 1, 1, 32'h8, 32'h600, 0, 0, 2, 0));
        s = mk(1, 13, 1, 2, 32'h8, 32'h700, 0, 0, 3, 0);
        s.fl = 1;
        step(s);
        check("flush ex_valid", ex_valid, 0);
        check("flush redir_valid", redir_valid, 0);
        check("flush keeps entry", pr_valid, 1);
        check("flush entry ticket", pr_ticket, 3'd2);
        idle(0);
        idle(1);
        check("flush drained", pr_valid, 0);

        // ---------------- random ----------------
        for (int n = 0; n < 2000; n++) begin
            s.v    = ($urandom_range(0, 9) < 8);
            s.uop  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(10, 21));
            s.a    = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            s.b    = $urandom_range(0, 1) ? s.a : 32'($urandom);
            s.imm  = $urandom_range(0, 1) ? (32'($urandom) & 32'h0000_0FFE) : 32'($urandom);
            s.pc   = 32'($urandom) & 32'hFFFF_FFFE;
            s.pt   = 1'($urandom_range(0, 1));
            s.ptgt = $urandom_range(0, 1) ? s.pc + s.imm : 32'($urandom);
            s.ticket = 3'($urandom); s.rat = 2'($urandom); s.dest = 6'($urandom);
            s.fl   = ($urandom_range(0, 19) == 0);
            s.prr  = ($urandom_range(0, 9) < 6);
            step(s);
        end

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 3; i++) step(mk(1, 10, 0, 0, 32'h8, 32'h900, 0, 0, i, 0));
        rst = 1; in_valid = 1; pr_ready = 1;
        @(posedge clk);
        #1 rst = 0; in_valid = 0;
        mq.delete();
        check("rst ex_valid", ex_valid, 0);
        check("rst redir_valid", redir_valid, 0);
        check("rst pr_valid", pr_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst ex_data", ex_data, 0);
        check("rst pr_orig_pc", pr_orig_pc, 0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolver_pipe.md
# branch_resolver_pipe

Registered, parametrised branch/shift/compare functional unit for the DRIM execute stage. It resolves all jumps and conditional branches and detects mispredictions against the front-end prediction carried with each instruction. It drives a one-cycle-latency writeback port and a redirect port, and buffers predictor updates in a small FIFO with valid/ready backpressure toward the predictors.

## Interface
- DATA_WIDTH, 32: operand/result/PC width (power of two, ≥32); shift amount uses low $clog2(DATA_WIDTH) bits.
- UPD_DEPTH, 4: predictor-update FIFO entries (power of two, ≥2).
- TICKET_W, 3 / RAT_W, 2 / DEST_W, 6: ROB ticket, RAT checkpoint id, destination register widths.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- flush  in  1  pipeline flush from commit.
- in_valid / in_ready  in/out  1  issue handshake; accepted when both high.
- in_uop  in  5  microoperation; in_data1, in_data2, in_imm, in_pc  in  DATA_WIDTH each.
- in_pred_taken  in  1; in_pred_target  in  DATA_WIDTH  front-end prediction.
- in_ticket, in_rat_id, in_dest  in  TICKET_W/RAT_W/DEST_W.
- ex_valid, ex_data, ex_ticket, ex_dest, ex_exc_valid, ex_exc_cause(5)  out  writeback.
- redir_valid  out  1; redir_pc  out  DATA_WIDTH; redir_ticket, redir_rat_id  out  misprediction redirect.
- pr_valid / pr_ready  out/in  1  predictor-update handshake; pr_taken, pr_is_comp  out 1; pr_orig_pc, pr_target  out DATA_WIDTH; pr_ticket, pr_rat_id  out.

## Operation
- uop codes: 0 SLT, 1 SLTU, 2 SLTI, 3 SLTIU, 4 SLL, 5 SRL, 6 SRA, 7 SLLI, 8 SRLI, 9 SRAI, 10 JAL, 11 JALR, 12 BEQ, 13 BNE, 14 BLT, 15 BLTU, 16 BGE, 17 BGEU, 18 C.JR/C.JALR, 19 C.J/C.JAL, 20 C.BEQZ, 21 C.BNEZ; 22–31 illegal.
- Compares: result 1/0, signed or unsigned per op; immediate forms use in_imm. SRA/SRAI true arithmetic shift (sign-filled).
- Branch target = pc+imm (10,12–17,19–21); JALR = (data1+imm) with bit0 cleared; C.JR = data1. Link result: pc+4 (10,11), pc+2 (18,19); branches result 0.
- JAL exception: target[1:0] misaligned (target[1] set without compressed support, or target[0] set) → exc_valid, cause 1. Illegal uop → exc_valid, cause 2, no jump. All arithmetic modulo 2^DATA_WIDTH.
- is_comp = uop 18–21. fallthrough = pc + (is_comp ? 2 : 4).
- Mispredict (jump ops only): taken≠pred_taken, or taken and target≠pred_target. redir_pc = taken ? target : fallthrough.
- Every accepted jump op pushes one FIFO entry {taken, is_comp, pc, target-or-fallthrough, ticket, rat_id}; non-jumps never push.
- in_ready = !fifo_full (applies to all ops). FIFO pointers wrap modulo UPD_DEPTH; count is $clog2(UPD_DEPTH)+1 bits.

## Timing
- Reset: ex_valid, redir_valid, pr_valid, ex_exc_valid = 0; all data/ticket outputs 0; FIFO empty; in_ready = 1 the cycle after rst deasserts.
- Accept at edge N → ex_* and redir_* valid for exactly cycle N+1 (one pipeline register, no stall; writeback always sinks).
- FIFO push at edge N → pr_valid high from N+1 if it was empty (no combinational bypass). Pop on pr_valid & pr_ready. Head data stable while pr_valid & !pr_ready.
- Full: in_ready low; simultaneous pop frees a slot next cycle only. Push+pop same edge: count unchanged.
- flush at edge N: same-cycle input discarded (no push), ex_valid/redir_valid 0 at N+1; FIFO contents retained (resolved updates stay valid).
- rst mid-operation overrides everything, including in-progress pop.

## Configuration
- BR_COMPRESSED_EN defined: uops 18–21 legal, pc+2 links, misalignment checks target[0] only.
- Undefined: uops 18–21 decode as illegal (cause 2, no push, no redirect); is_comp always 0; JAL misaligned when target[1:0]≠0.

## Test plan
- BLT data1=-1, data2=1, pc=0x100, imm=0x20, pred_taken=0 → N+1: redir_valid=1, redir_pc=0x120; pr entry taken=1, target=0x120.
- JALR data1=0x203, imm=0, pred target 0x202, pred_taken=1 → ex_data=pc+4, target 0x202, no redirect, no exception.
- SRA data1=0x80000000, data2=4 → ex_data=0xF8000000, no FIFO push.
- pr_ready=0, issue UPD_DEPTH+1 BEQs back-to-back → in_ready low after UPD_DEPTH pushes; raise pr_ready → entries drain in order, no loss/duplication.
- flush with a BNE offered the same cycle → no ex_valid, no push; earlier FIFO entries still delivered.
- uop 20 (C.BEQZ) data1=0: with BR_COMPRESSED_EN → taken, is_comp=1; without → ex_exc_valid=1, cause 2.
